// File: rtl/multi_input_buffer.sv
// Multi-channel frame capture buffer: on each frame trigger, captures 2**FFT samples per ADC channel, then
// streams the frames channel by channel. Defining MIB_TIMESTAMP_EN adds the source_time capture timestamp port.
module multi_input_buffer #(
  parameter int NSINK  = 3,
  parameter int WIDTH  = 14,
  parameter int FFT    = 11,
  parameter int FREQ   = 5000,
  parameter int CLK_HZ = 40000000,
  parameter int DECIM  = 1,
  localparam int CW    = (NSINK > 1) ? $clog2(NSINK) : 1
) (
  input  logic                    clk40,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sink [0:NSINK-1],
  input  logic                    sink_valid,
  input  logic                    source_ready,
  output logic                    source_valid,
  output logic                    source_sop,
  output logic                    source_eop,
  output logic [CW-1:0]           source_channel,
  output logic signed [WIDTH-1:0] source_data,
  output logic                    busy,
`ifdef MIB_TIMESTAMP_EN
  output logic [31:0]             source_time,
`endif
  output logic [7:0]              overrun_cnt
);

  localparam int N  = 2**FFT;
  localparam int P  = CLK_HZ / FREQ;
  localparam int PW = $clog2(P);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [CW-1:0]           ch;
    logic signed [WIDTH-1:0] data;
  } word_t;

  state_t                  state, state_next;
  logic [PW-1:0]           period_cnt;
  logic                    tick, pending, start;
  logic [DW-1:0]           decim_cnt;
  logic [FFT-1:0]          wr_addr;
  logic                    keep, cap_done;
  logic signed [WIDTH-1:0] mem [0:NSINK-1][0:N-1];
  logic [CW-1:0]           iss_ch;
  logic [FFT-1:0]          iss_addr;
  logic                    iss_done, issue;
  logic                    rd_vld, rd_sop, rd_eop;
  logic [CW-1:0]           rd_ch;
  logic signed [WIDTH-1:0] rd_data;
  word_t                   rd_word, skid0, skid1;
  logic [1:0]              skid_cnt;
  logic                    pop, last_pop;

  assign tick     = (period_cnt == PW'(P - 1));
  assign start    = (state == IDLE) && (state_next == CAPTURE);
  assign keep     = (state == CAPTURE) && sink_valid && (decim_cnt == '0);
  assign cap_done = keep && (wr_addr == FFT'(N - 1));
  assign pop      = source_valid && source_ready;
  assign last_pop = pop && skid0.eop && (skid0.ch == CW'(NSINK - 1));
  // Only request a read when the skid is guaranteed room for it one cycle later.
  assign issue    = (state == STREAM) && !iss_done &&
                    ((3'(skid_cnt) + 3'(rd_vld)) < (3'd2 + 3'(pop)));
  assign rd_word  = {rd_sop, rd_eop, rd_ch, rd_data};

  assign source_valid   = (skid_cnt != 2'd0);
  assign source_sop     = skid0.sop;
  assign source_eop     = skid0.eop;
  assign source_channel = skid0.ch;
  assign source_data    = skid0.data;
  assign busy           = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending || tick) state_next = CAPTURE;
      CAPTURE: if (cap_done) state_next = STREAM;
      STREAM:  if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A tick seen in IDLE starts the capture directly; one arriving while a trigger is already queued is dropped.
  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      period_cnt  <= '0;
      pending     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      period_cnt <= tick ? '0 : period_cnt + 1'b1;
      if (start)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;
      if (tick && pending && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      decim_cnt <= '0;
      wr_addr   <= '0;
    end else if (start) begin
      decim_cnt <= '0;
      wr_addr   <= '0;
    end else if ((state == CAPTURE) && sink_valid) begin
      decim_cnt <= (decim_cnt == DW'(DECIM - 1)) ? '0 : decim_cnt + 1'b1;
      if (keep)
        wr_addr <= wr_addr + 1'b1;
    end
  end

  always_ff @(posedge clk40) begin
    if (keep)
      for (int c = 0; c < NSINK; c++)
        mem[c][wr_addr] <= sink[c];
    if (issue)
      rd_data <= mem[iss_ch][iss_addr];
  end

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      iss_ch   <= '0;
      iss_addr <= '0;
      iss_done <= 1'b0;
      rd_vld   <= 1'b0;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
      rd_ch    <= '0;
    end else begin
      rd_vld <= issue;
      if (start) begin
        iss_ch   <= '0;
        iss_addr <= '0;
        iss_done <= 1'b0;
      end else if (issue) begin
        rd_sop   <= (iss_addr == '0);
        rd_eop   <= (iss_addr == FFT'(N - 1));
        rd_ch    <= iss_ch;
        iss_addr <= iss_addr + 1'b1;
        if (iss_addr == FFT'(N - 1)) begin
          if (iss_ch == CW'(NSINK - 1))
            iss_done <= 1'b1;
          else
            iss_ch <= iss_ch + 1'b1;
        end
      end
    end
  end

  // Two-entry skid; skid0 is the presented word and only moves when it is accepted.
  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      case ({rd_vld, pop})
        2'b10: begin
          if (skid_cnt == 2'd0)
            skid0 <= rd_word;
          else
            skid1 <= rd_word;
          skid_cnt <= skid_cnt + 1'b1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 1'b1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= rd_word;
          end else begin
            skid0 <= skid1;
            skid1 <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MIB_TIMESTAMP_EN
  logic [31:0] time_cnt;

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      time_cnt    <= 32'd0;
      source_time <= 32'd0;
    end else begin
      time_cnt <= time_cnt + 1'b1;
      if (start)
        source_time <= time_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_input_buffer.sv
// Directed bench for multi_input_buffer: dut_a (DECIM=1, P=200) covers reset, framing, backpressure and reset
// mid-stream; dut_b (DECIM=4, P=20) covers decimation and overrun saturation.
module tb_multi_input_buffer;
  localparam int NSINK = 3;
  localparam int WIDTH = 14;
  localparam int FFT   = 4;
  localparam int N     = 16;
  localparam int P_A   = 200;
  localparam int P_B   = 20;

  logic clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  logic                    reset_a, reset_b, sink_valid, ready_a, ready_b;
  logic signed [WIDTH-1:0] sink [0:NSINK-1];
  logic                    valid_a, sop_a, eop_a, busy_a;
  logic                    valid_b, sop_b, eop_b, busy_b;
  logic [1:0]              ch_a, ch_b;
  logic signed [WIDTH-1:0] data_a, data_b;
  logic [7:0]              ovr_a, ovr_b;
`ifdef MIB_TIMESTAMP_EN
  logic [31:0]             time_a, time_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int samp   = 0;
  int got, first, last;

  multi_input_buffer #(
    .NSINK(NSINK), .WIDTH(WIDTH), .FFT(FFT), .FREQ(1), .CLK_HZ(P_A), .DECIM(1)
  ) dut_a (
    .clk40(clk40), .reset(reset_a), .sink(sink), .sink_valid(sink_valid), .source_ready(ready_a),
    .source_valid(valid_a), .source_sop(sop_a), .source_eop(eop_a), .source_channel(ch_a),
    .source_data(data_a), .busy(busy_a),
`ifdef MIB_TIMESTAMP_EN
    .source_time(time_a),
`endif
    .overrun_cnt(ovr_a)
  );

  multi_input_buffer #(
    .NSINK(NSINK), .WIDTH(WIDTH), .FFT(FFT), .FREQ(1), .CLK_HZ(P_B), .DECIM(4)
  ) dut_b (
    .clk40(clk40), .reset(reset_b), .sink(sink), .sink_valid(sink_valid), .source_ready(ready_b),
    .source_valid(valid_b), .source_sop(sop_b), .source_eop(eop_b), .source_channel(ch_b),
    .source_data(data_b), .busy(busy_b),
`ifdef MIB_TIMESTAMP_EN
    .source_time(time_b),
`endif
    .overrun_cnt(ovr_b)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic driveSink();
    for (int c = 0; c < NSINK; c++)
      sink[c] = WIDTH'(c * 100 + samp);
  endtask

  // Sink ramp: the sample clocked in on edge k after a reset release is c*100 + (k-1).
  task automatic applyStimulus();
    @(posedge clk40);
    #1;
    cyc++;
    samp++;
    driveSink();
  endtask

  task automatic restart();
    cyc  = 0;
    samp = 0;
    driveSink();
  endtask

  task automatic checkIdleA(input string pfx);
    checkOutput({pfx, "_valid"}, valid_a, 0);
    checkOutput({pfx, "_sop"}, sop_a, 0);
    checkOutput({pfx, "_eop"}, eop_a, 0);
    checkOutput({pfx, "_channel"}, ch_a, 0);
    checkOutput({pfx, "_data"}, data_a, 0);
    checkOutput({pfx, "_busy"}, busy_a, 0);
    checkOutput({pfx, "_overrun"}, ovr_a, 0);
  endtask

  task automatic checkIdleB(input string pfx);
    checkOutput({pfx, "_valid"}, valid_b, 0);
    checkOutput({pfx, "_sop"}, sop_b, 0);
    checkOutput({pfx, "_eop"}, eop_b, 0);
    checkOutput({pfx, "_channel"}, ch_b, 0);
    checkOutput({pfx, "_data"}, data_b, 0);
    checkOutput({pfx, "_busy"}, busy_b, 0);
    checkOutput({pfx, "_overrun"}, ovr_b, 0);
  endtask

  task automatic checkWord(input int idx, input int base);
    int ch   = idx / N;
    int addr = idx % N;
    checkOutput($sformatf("word%0d_data", idx), data_a, ch * 100 + base + addr);
    checkOutput($sformatf("word%0d_channel", idx), ch_a, ch);
    checkOutput($sformatf("word%0d_sop", idx), sop_a, addr == 0);
    checkOutput($sformatf("word%0d_eop", idx), eop_a, addr == N - 1);
  endtask

  // Every cycle with valid high must present the next expected word, whether or not it is accepted.
  task automatic collectFrame(input int base, input bit rand_ready, input int stop_at,
                              output int n_got, output int first_cyc, output int last_cyc);
    n_got = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int k = 0; k < 400 && n_got < stop_at; k++) begin
      ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_a) begin
        checkWord(n_got, base);
        if (ready_a) begin
          if (n_got == 0) first_cyc = cyc;
          last_cyc = cyc;
          n_got++;
        end
      end
      applyStimulus();
    end
    ready_a = 1'b1;
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    sink_valid = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    restart();
    repeat (5) applyStimulus();
    checkIdleA("t1_reset_a");
    checkIdleB("t1_reset_b");

    reset_a = 1'b1;
    restart();
    while (!busy_a && cyc < 400) applyStimulus();
    checkOutput("t1_busy_rise_cycle", cyc, P_A);

    collectFrame(P_A, 1'b0, 48, got, first, last);
    checkOutput("t2_word_count", got, 48);
    checkOutput("t2_first_valid_cycle", first, 218);
    checkOutput("t2_last_transfer_cycle", last, 265);
    checkOutput("t2_busy_after", busy_a, 0);
    checkOutput("t2_valid_after", valid_a, 0);

    collectFrame(2 * P_A, 1'b1, 48, got, first, last);
    checkOutput("t4_word_count", got, 48);
    checkOutput("t4_overrun_none", ovr_a, 0);

    collectFrame(3 * P_A, 1'b0, 20, got, first, last);
    checkOutput("t6_words_before_reset", got, 20);
    reset_a = 1'b0;
    #1;
    checkIdleA("t6_async");
    applyStimulus();
    checkIdleA("t6_held");
    reset_a = 1'b1;
    restart();
    while (!busy_a && cyc < 400) applyStimulus();
    checkOutput("t6_busy_rise_cycle", cyc, P_A);
    collectFrame(P_A, 1'b0, 1, got, first, last);
    checkOutput("t6_first_word_count", got, 1);
    checkOutput("t6_first_valid_cycle", first, 218);
`ifdef MIB_TIMESTAMP_EN
    checkOutput("t6_source_time", time_a, P_A);
`endif

    checkIdleB("b_held_reset");
    reset_b = 1'b1;
    restart();
    while (!busy_b && cyc < 100) applyStimulus();
    checkOutput("t5_busy_rise_cycle", cyc, P_B);
    while (cyc < 50) applyStimulus();
    checkOutput("t5_overrun_at_50", ovr_b, 0);
    while (cyc < 65) applyStimulus();
    checkOutput("t5_overrun_at_65", ovr_b, 1);
    while (!valid_b && cyc < 200) applyStimulus();
    checkOutput("t3_first_valid_cycle", cyc, 83);
    checkOutput("t3_word0_data", data_b, 20);
    checkOutput("t3_word0_sop", sop_b, 1);
    checkOutput("t3_word0_channel", ch_b, 0);
    applyStimulus();
    checkOutput("t3_word1_valid", valid_b, 1);
    checkOutput("t3_word1_data", data_b, 24);
    checkOutput("t3_word1_sop", sop_b, 0);
    while (cyc < 125) applyStimulus();
    checkOutput("t5_overrun_at_125", ovr_b, 4);
    while (cyc < 10000) applyStimulus();
    checkOutput("t5_overrun_saturated", ovr_b, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
